// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stall, branch flush, mul/div sequencing.
// Optional stall counter enabled by HAZARD_CTRL_PERF_EN.
module hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             IdEx_MemRead,
  input  logic [4:0]       IdEx_RegRd,
  input  logic             IdEx_MdStart,
  input  logic [4:0]       IfId_RegRs1,
  input  logic [4:0]       IfId_RegRs2,
  input  logic             IfId_UseRs2,
  input  logic             Ex_BranchTaken,
  output logic             Pc_Write,
  output logic             IfId_Write,
  output logic             IfId_Flush,
  output logic             IdEx_Bubble,
  output logic             IdEx_Hold,
  output logic             ExMem_Bubble,
  output logic             Md_Start,
  output logic             Md_Busy,
  output logic             Md_Done,
  output logic [CNT_W-1:0] Stall_Cnt
);

  localparam int MW = $clog2(MD_LAT);
  localparam logic [MW-1:0] MD_INIT = MW'(MD_LAT - 2);

  typedef enum logic {
    RUN,
    MD_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [MW-1:0] md_cnt_q, md_cnt_d;

  logic load_use;
  logic pc_w, ifid_w, ifid_fl;
  logic idex_bub, idex_hold, exmem_bub;
  logic md_start, md_busy, md_done;

  assign load_use = IdEx_MemRead
                  && (IdEx_RegRd != 5'd0)
                  && ((IdEx_RegRd == IfId_RegRs1)
                   || (IfId_UseRs2
                    && (IdEx_RegRd == IfId_RegRs2)));

  // Next state and hazard controls from current state and inputs.
  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    pc_w      = 1'b1;
    ifid_w    = 1'b1;
    ifid_fl   = 1'b0;
    idex_bub  = 1'b0;
    idex_hold = 1'b0;
    exmem_bub = 1'b0;
    md_start  = 1'b0;
    md_busy   = 1'b0;
    md_done   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (IdEx_MdStart) begin
          md_start  = 1'b1;
          md_busy   = 1'b1;
          pc_w      = 1'b0;
          ifid_w    = 1'b0;
          idex_hold = 1'b1;
          exmem_bub = 1'b1;
          md_cnt_d  = MD_INIT;
          state_d   = MD_WAIT;
        end else if (Ex_BranchTaken) begin
          ifid_fl  = 1'b1;
          idex_bub = 1'b1;
        end else if (load_use) begin
          pc_w     = 1'b0;
          ifid_w   = 1'b0;
          idex_bub = 1'b1;
        end
      end
      MD_WAIT: begin
        md_busy = 1'b1;
        if (md_cnt_q != '0) begin
          pc_w      = 1'b0;
          ifid_w    = 1'b0;
          idex_hold = 1'b1;
          exmem_bub = 1'b1;
          md_cnt_d  = md_cnt_q - 1'b1;
        end else begin
          md_done = 1'b1;
          state_d = RUN;
          if (load_use) begin
            pc_w     = 1'b0;
            ifid_w   = 1'b0;
            idex_bub = 1'b1;
          end
        end
      end
    endcase
  end

  // State and mul/div countdown registers.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q  <= RUN;
      md_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      md_cnt_q <= md_cnt_d;
    end
  end

  // Reset holds the pipeline frozen with NOPs in flight.
  always_comb begin
    Pc_Write     = pc_w;
    IfId_Write   = ifid_w;
    IfId_Flush   = ifid_fl;
    IdEx_Bubble  = idex_bub;
    IdEx_Hold    = idex_hold;
    ExMem_Bubble = exmem_bub;
    Md_Start     = md_start;
    Md_Busy      = md_busy;
    Md_Done      = md_done;
    if (!rstb) begin
      Pc_Write     = 1'b0;
      IfId_Write   = 1'b0;
      IfId_Flush   = 1'b1;
      IdEx_Bubble  = 1'b1;
      IdEx_Hold    = 1'b0;
      ExMem_Bubble = 1'b1;
      Md_Start     = 1'b0;
      Md_Busy      = 1'b0;
      Md_Done      = 1'b0;
    end
  end

`ifdef HAZARD_CTRL_PERF_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating count of cycles with the PC frozen.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!Pc_Write && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign Stall_Cnt = stall_cnt_q;
`else
  assign Stall_Cnt = '0;
`endif

endmodule
